// File: rtl/clk_mux_ctrl.sv
// rtl/clk_mux_ctrl.sv - round-robin arbitrated controller for a glitch-free clock mux select
//
// Arbitrates switch requests from NUM_REQ requesters, drives the clock mux
// select, waits SETTLE_CYCLES for the mux to finish switching, grants the
// winner, then holds off further switches for DWELL_CYCLES.
//
// Ports:
//   clk_i      always-on reference clock
//   rst_ni     synchronous active-low reset
//   req_i      per-requester switch request (level, held until grant)
//   req_sel_i  clock source wanted by each requester
//   lock_i     high blocks new arbitration (IDLE only)
//   sel_o      clock mux select
//   gnt_o      one-hot single-cycle completion pulse
//   busy_o     high while a switch settles or dwell runs
module clk_mux_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 64,
  parameter bit SEL_RST       = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_sel_i,
  input  logic               lock_i,
  output logic               sel_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               busy_o
);

  localparam int MAX_CNT = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               sel_q, sel_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic               any_req;
  logic [IDX_W-1:0]   pick;

  // (base + off) mod NUM_REQ, with off < NUM_REQ
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan from ptr_q upward; iterating offsets downward
  // lets the lowest offset with a request overwrite the others.
  always_comb begin
    any_req = |req_i;
    pick    = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[rr_idx(ptr_q, i)]) pick = rr_idx(ptr_q, i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        // Skipping arbitration while a grant is on the output keeps grants
        // separated by a zero cycle and gives the requester time to drop req.
        if (!lock_i && any_req && (gnt_q == '0)) begin
          win_d = pick;
          ptr_d = rr_idx(pick, 1);
          if (req_sel_i[pick] == sel_q) begin
            gnt_d = onehot(pick);
          end else begin
            sel_d   = req_sel_i[pick];
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          gnt_d = onehot(win_q);
          if (DWELL_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DWELL;
            cnt_d   = DWELL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      sel_q   <= SEL_RST;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
    end
  end

  assign sel_o  = sel_q;
  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_clk_mux_ctrl.sv
// tb/tb_clk_mux_ctrl.sv - scoreboard testbench for clk_mux_ctrl
module tb_clk_mux_ctrl;
  localparam int N = 4;
  localparam int S = 16;
  localparam int D = 64;
  localparam int P = S + D + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lock = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_sel = '0;
  logic         sel;
  logic [N-1:0] gnt;
  logic         busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] gnt;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_m;
  logic [N-1:0] gnt_prev = '0;

  clk_mux_ctrl #(
    .NUM_REQ(N),
    .SETTLE_CYCLES(S),
    .DWELL_CYCLES(D),
    .SEL_RST(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req),
    .req_sel_i(req_sel),
    .lock_i(lock),
    .sel_o(sel),
    .gnt_o(gnt),
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every grant must match the head of the scoreboard.
  always @(negedge clk) begin
    if (gnt !== '0) begin
      chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      chk("gnt_gap", 32'(gnt_prev), 32'd0);
      if (exp_q.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        e_m = exp_q.pop_front();
        chk("gnt_value", 32'(gnt), 32'(e_m.gnt));
        chk("gnt_cycle", 32'(cyc), 32'(e_m.cyc));
      end
    end
    gnt_prev = gnt;
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    repeat (4) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Same-select request on the first edge out of reset: grant next cycle, no busy
    rst_n = 1'b1;
    req = 4'b0100; req_sel = 4'b0000;
    e = cyc + 1;
    exp_q.push_back('{4'b0100, e});
    @(negedge clk);
    chk("match_busy", 32'(busy), 32'd0);
    chk("match_sel", 32'(sel), 32'd0);
    req = '0;
    @(negedge clk);
    chk("match_busy2", 32'(busy), 32'd0);
    chk("match_gnt_clr", 32'(gnt), 32'd0);

    // Switch 0 -> 1 by requester 0: busy e..e+S+D-1, grant at e+S
    @(negedge clk);
    req = 4'b0001; req_sel = 4'b0001;
    e = cyc + 1;
    exp_q.push_back('{4'b0001, e + S});
    @(negedge clk);
    chk("sw_sel", 32'(sel), 32'd1);
    chk("sw_busy_first", 32'(busy), 32'd1);
    to_cyc(e + S);
    req = '0;
    to_cyc(e + S + D - 1);
    chk("sw_busy_last", 32'(busy), 32'd1);
    to_cyc(e + S + D);
    chk("sw_busy_end", 32'(busy), 32'd0);
    chk("sw_sel_hold", 32'(sel), 32'd1);

    // Locked for 20 cycles, then arbitration on first unlocked edge;
    // requester drops in 5th SETTLE cycle but is still granted
    lock = 1'b1; req = 4'b0010; req_sel = 4'b0000;
    repeat (20) @(negedge clk);
    chk("lock_busy", 32'(busy), 32'd0);
    chk("lock_sel", 32'(sel), 32'd1);
    lock = 1'b0;
    e = cyc + 1;
    exp_q.push_back('{4'b0010, e + S});
    @(negedge clk);
    chk("unlock_sel", 32'(sel), 32'd0);
    chk("unlock_busy", 32'(busy), 32'd1);
    to_cyc(e + 4);
    req = '0;
    lock = 1'b1;
    to_cyc(e + S + D - 1);
    chk("drop_busy_last", 32'(busy), 32'd1);
    lock = 1'b0;
    to_cyc(e + S + D);
    chk("drop_busy_end", 32'(busy), 32'd0);

    // Reset in 8th SETTLE cycle: aborts with no grant, sel back to 0
    req = 4'b0100; req_sel = 4'b0100;
    e = cyc + 1;
    @(negedge clk);
    chk("abort_sel_pre", 32'(sel), 32'd1);
    to_cyc(e + 7);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // All four requesting, alternating targets: grants 0,1,2,3,0 every P cycles
    // (starting at 0 also shows ptr was cleared by the reset above)
    req = 4'b1111; req_sel = 4'b0101;
    e = cyc + 1;
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back('{4'(1 << (n % 4)), e + S + P * n});
    end
    to_cyc(e + S + P * 4);
    req = '0;
    to_cyc(e + P * 4 + S + D);
    chk("rr_busy_end", 32'(busy), 32'd0);
    chk("rr_sel_end", 32'(sel), 32'd1);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
